// File: rtl/game_state_machine.sv
// Game flow controller: idle -> playing -> hit (freeze) -> gameover -> idle.
// Outputs are registered and move on the same edge as the state register.
module game_state_machine #(
    parameter int HIT_CYCLES        = 25000000,
    parameter int GO_MIN_CYCLES     = 50000000,
    parameter int GO_TIMEOUT_CYCLES = 1000000000,
    parameter int CNT_W             = 30
) (
    input  logic       clk,
    input  logic       hard_reset_n,
    input  logic       start,
    input  logic       collision,
    output logic [2:0] game_state,
    output logic       game_en,
    output logic       game_reset
);

    typedef enum logic [2:0] {
        IDLE     = 3'b001,
        PLAYING  = 3'b010,
        HIT      = 3'b011,
        GAMEOVER = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(HIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GO_MIN   = CNT_W'(GO_MIN_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(GO_TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             start_q;
    logic             start_edge;
    logic             pulse_d;

    assign start_edge = start & ~start_q;
    assign game_state = state;

    always_comb begin
        state_d = state;
        pulse_d = 1'b0;
        cnt_d   = '0;
        unique case (state)
            IDLE: begin
                // A pulse still high from gameover exit blocks a back-to-back pulse.
                if (start_edge && !game_reset) begin
                    state_d = PLAYING;
                    pulse_d = 1'b1;
                end
            end
            PLAYING: begin
                if (collision)
                    state_d = HIT;
            end
            HIT: begin
                if (cnt == HIT_LAST)
                    state_d = GAMEOVER;
                else
                    cnt_d = cnt + 1'b1;
            end
            GAMEOVER: begin
                if (cnt == TO_LAST || (start_edge && cnt >= GO_MIN)) begin
                    state_d = IDLE;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!hard_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            start_q    <= 1'b0;
            game_en    <= 1'b0;
            game_reset <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            start_q    <= start;
            game_en    <= (state_d == PLAYING);
            game_reset <= pulse_d;
        end
    end

endmodule

// File: tb/tb_game_state_machine.sv
// Bench for game_state_machine: directed scenarios then random traffic,
// every cycle compared against a mode/elapsed-time reference model.
module tb_game_state_machine;

    localparam int HIT  = 4;
    localparam int GMIN = 8;
    localparam int GTO  = 20;

    logic       clk = 1'b0;
    logic       hard_reset_n = 1'b0;
    logic       start = 1'b0;
    logic       collision = 1'b0;
    logic [2:0] game_state;
    logic       game_en;
    logic       game_reset;

    int errors = 0;
    int checks = 0;

    int m_state = 1;
    int m_t     = 0;
    bit m_sq    = 1'b0;
    bit m_pulse = 1'b0;
    bit prev_rst_out = 1'b0;

    game_state_machine #(
        .HIT_CYCLES(HIT),
        .GO_MIN_CYCLES(GMIN),
        .GO_TIMEOUT_CYCLES(GTO),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .hard_reset_n(hard_reset_n),
        .start(start),
        .collision(collision),
        .game_state(game_state),
        .game_en(game_en),
        .game_reset(game_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Game rules in terms of mode and cycles spent in that mode.
    task automatic model_step(input bit r, input bit s, input bit c);
        bit edge_s;
        int nxt;
        bit pl;
        if (!r) begin
            m_state = 1; m_t = 0; m_sq = 0; m_pulse = 0;
            return;
        end
        edge_s = s && !m_sq;
        m_sq = s;
        nxt = m_state;
        pl = 0;
        if (m_state == 1 && edge_s && !m_pulse) begin
            nxt = 2; pl = 1;
        end else if (m_state == 2 && c) begin
            nxt = 3;
        end else if (m_state == 3 && m_t == HIT - 1) begin
            nxt = 4;
        end else if (m_state == 4 &&
                     ((edge_s && m_t >= GMIN) || m_t == GTO - 1)) begin
            nxt = 1; pl = 1;
        end
        if (nxt != m_state || nxt == 1 || nxt == 2) m_t = 0;
        else if (m_t < GTO - 1) m_t++;
        m_state = nxt;
        m_pulse = pl;
    endtask

    task automatic tick(input bit r, input bit s, input bit c);
        hard_reset_n = r; start = s; collision = c;
        @(posedge clk);
        model_step(r, s, c);
        #1;
        chk("state", int'(game_state), m_state);
        chk("en", int'(game_en), int'(m_state == 2));
        chk("reset", int'(game_reset), int'(m_pulse));
        chk("pulse_consec", int'(prev_rst_out && game_reset), 0);
        prev_rst_out = game_reset;
    endtask

    task automatic advance(input int st, input int t);
        int n = 0;
        while (!(m_state == st && m_t == t) && n < 100) begin
            tick(1, 0, 0);
            n++;
        end
        chk("advance_bound", int'(n < 100), 1);
    endtask

    task automatic press_to_play();
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 1, 0);
        chk("play_state", int'(game_state), 2);
        chk("play_pulse", int'(game_reset), 1);
        tick(1, 0, 0);
    endtask

    initial begin
        // Reset and start with a held key
        repeat (3) tick(0, 0, 0);
        chk("rst_state", int'(game_state), 1);
        chk("rst_en", int'(game_en), 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 10; i++) tick(1, 1, 0);
        chk("held_state", int'(game_state), 2);
        chk("held_en", int'(game_en), 1);
        tick(1, 0, 0);

        // Collision freeze
        tick(1, 0, 1);
        chk("hit_state", int'(game_state), 3);
        chk("hit_en", int'(game_en), 0);
        for (int i = 0; i < 3; i++) tick(1, 0, 0);
        chk("hit_hold", int'(game_state), 3);
        tick(1, 0, 0);
        chk("go_state", int'(game_state), 4);

        // Lockout then accepted start
        advance(4, 3);
        tick(1, 1, 0);
        chk("lockout", int'(game_state), 4);
        tick(1, 0, 0);
        advance(4, 9);
        tick(1, 1, 0);
        chk("go_exit_state", int'(game_state), 1);
        chk("go_exit_pulse", int'(game_reset), 1);

        // Timeout
        press_to_play();
        tick(1, 0, 1);
        advance(4, 0);
        for (int i = 0; i < GTO - 1; i++) tick(1, 0, 0);
        chk("to_before", int'(game_state), 4);
        tick(1, 0, 0);
        chk("to_state", int'(game_state), 1);
        chk("to_pulse", int'(game_reset), 1);

        // Collision and start edge together
        press_to_play();
        tick(1, 0, 0);
        tick(1, 1, 1);
        chk("simul_state", int'(game_state), 3);
        chk("simul_pulse", int'(game_reset), 0);

        // Reset mid-hit, mid-gameover
        advance(3, 2);
        tick(0, 0, 0);
        chk("rst_hit", int'(game_state), 1);
        press_to_play();
        tick(1, 0, 1);
        advance(4, 5);
        tick(0, 0, 0);
        chk("rst_go", int'(game_state), 1);
        chk("rst_go_pulse", int'(game_reset), 0);
        press_to_play();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit s;
            s = ($urandom_range(7) == 0) ? !start : start;
            tick(($urandom_range(199) != 0), s, ($urandom_range(9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
